mul_div_unit: RTL and testbench

Multiply/divide unit in the execute stage of the five-stage MIPS pipeline. It consumes `MduStart`/`MDUType` from the instruction decoder, together with the forwarded rs/rt operands. It runs multi-cycle signed and unsigned multiply and divide into the HI/LO registers, executes single-cycle `mthi`/`mtlo` writes, and supplies HI or LO for `mfhi`/`mflo` writeback. It exports `busy` so the hazard unit can stall dependent MDU instructions.

---
 rtl/mul_div_unit_if.sv | 22 ++
 rtl/mul_div_unit.sv | 133 +++++++++++++
 tb/tb_mul_div_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - execute-stage MDU request/response bundle
interface mul_div_unit_if;
    logic        start;
    logic [3:0]  mdu_type;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        req;
    logic        busy;
    logic [31:0] mdu_out;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdu_type, src_a, src_b, req,
        input  busy, mdu_out, hi, lo
    );

    modport slave (
        input  start, mdu_type, src_a, src_b, req,
        output busy, mdu_out, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MIPS multiply/divide unit with HI/LO registers
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           reset,
    mul_div_unit_if.slave mdu
);
    localparam logic [3:0] T_MULT  = 4'd1;
    localparam logic [3:0] T_MULTU = 4'd2;
    localparam logic [3:0] T_DIV   = 4'd3;
    localparam logic [3:0] T_DIVU  = 4'd4;
    localparam logic [3:0] T_MFHI  = 4'd5;
    localparam logic [3:0] T_MFLO  = 4'd6;
    localparam logic [3:0] T_MTHI  = 4'd7;
    localparam logic [3:0] T_MTLO  = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, nextState;
    logic [15:0] cnt;
    logic [31:0] hiReg, loReg;
    logic [31:0] pendHi, pendLo;
    logic        pendWrite;

    logic        accept;
    logic        isMulDiv;
    logic [31:0] opA, opB;
    logic [63:0] prodS, prodU;
    logic [31:0] magA, magB;
    logic [31:0] quoMag, remMag, quoS, remS;
    logic [31:0] quoU, remU;

    assign opA      = mdu.src_a;
    assign opB      = mdu.src_b;
    assign accept   = mdu.start && !mdu.req && (state == IDLE);
    assign isMulDiv = (mdu.mdu_type == T_MULT) || (mdu.mdu_type == T_MULTU) ||
                      (mdu.mdu_type == T_DIV)  || (mdu.mdu_type == T_DIVU);

    // Products are computed at accept time; the busy period only models latency.
    assign prodS = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};
    assign prodU = {32'd0, opA} * {32'd0, opB};

    // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN naturally.
    assign magA   = opA[31] ? (~opA + 32'd1) : opA;
    assign magB   = opB[31] ? (~opB + 32'd1) : opB;
    assign quoMag = (magB == 32'd0) ? 32'd0 : magA / magB;
    assign remMag = (magB == 32'd0) ? 32'd0 : magA % magB;
    assign quoS   = (opA[31] ^ opB[31]) ? (~quoMag + 32'd1) : quoMag;
    assign remS   = opA[31] ? (~remMag + 32'd1) : remMag;
    assign quoU   = (opB == 32'd0) ? 32'd0 : opA / opB;
    assign remU   = (opB == 32'd0) ? 32'd0 : opA % opB;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Enter BUSY on an accepted mult/div; leave on the last counted cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (accept && isMulDiv) nextState = BUSY;
            BUSY: if (cnt <= 16'd1)       nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: latch pending results, count down, commit, and apply mthi/mtlo.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= 16'd0;
            hiReg     <= 32'd0;
            loReg     <= 32'd0;
            pendHi    <= 32'd0;
            pendLo    <= 32'd0;
            pendWrite <= 1'b0;
        end else if (accept) begin
            case (mdu.mdu_type)
                T_MULT: begin
                    {pendHi, pendLo} <= prodS;
                    pendWrite        <= 1'b1;
                    cnt              <= 16'(MULT_CYCLES);
                end
                T_MULTU: begin
                    {pendHi, pendLo} <= prodU;
                    pendWrite        <= 1'b1;
                    cnt              <= 16'(MULT_CYCLES);
                end
                T_DIV: begin
                    pendHi    <= remS;
                    pendLo    <= quoS;
                    pendWrite <= (opB != 32'd0);
                    cnt       <= 16'(DIV_CYCLES);
                end
                T_DIVU: begin
                    pendHi    <= remU;
                    pendLo    <= quoU;
                    pendWrite <= (opB != 32'd0);
                    cnt       <= 16'(DIV_CYCLES);
                end
                T_MTHI:  hiReg <= opA;
                T_MTLO:  loReg <= opA;
                default: ;
            endcase
        end else if (state == BUSY) begin
            cnt <= cnt - 16'd1;
            if (cnt <= 16'd1) begin
                pendWrite <= 1'b0;
                if (pendWrite) begin
                    hiReg <= pendHi;
                    loReg <= pendLo;
                end
            end
        end
    end

    // Read port always shows committed HI/LO.
    always_comb begin
        mdu.mdu_out = 32'd0;
        case (mdu.mdu_type)
            T_MFHI:  mdu.mdu_out = hiReg;
            T_MFLO:  mdu.mdu_out = loReg;
            default: mdu.mdu_out = 32'd0;
        endcase
    end

    assign mdu.busy = (state == BUSY);
    assign mdu.hi   = hiReg;
    assign mdu.lo   = loReg;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mul_div_unit_if bus();

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (bus)
    );

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [3:0]  t;
        logic [31:0] a;
        logic [31:0] b;
        bit          r;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expN;
        string       name;
    } vec_t;

    vec_t vecs[12];
    logic [31:0] mHi, mLo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: architectural MIPS HI/LO semantics from plain integer arithmetic.
    task automatic model(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                         input bit r, input logic [31:0] hiIn, input logic [31:0] loIn,
                         output logic [31:0] hiOut, output logic [31:0] loOut, output int n);
        longint sp;
        logic [63:0] up;
        int sa, sb;
        hiOut = hiIn;
        loOut = loIn;
        n = 0;
        sa = a;
        sb = b;
        if (!r) begin
            case (t)
                4'd1: begin sp = longint'(sa) * longint'(sb); {hiOut, loOut} = sp; n = 5; end
                4'd2: begin up = {32'd0, a} * {32'd0, b}; {hiOut, loOut} = up; n = 5; end
                4'd3: begin
                    n = 10;
                    if (b != 32'd0) begin
                        if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                            loOut = 32'h80000000;
                            hiOut = 32'd0;
                        end else begin
                            loOut = sa / sb;
                            hiOut = sa % sb;
                        end
                    end
                end
                4'd4: begin
                    n = 10;
                    if (b != 32'd0) begin
                        loOut = a / b;
                        hiOut = a % b;
                    end
                end
                4'd7: hiOut = a;
                4'd8: loOut = a;
                default: ;
            endcase
        end
    endtask

    task automatic runOp(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                         input bit r, input logic [31:0] expHi, input logic [31:0] expLo,
                         input int expN, input string name);
        int busyCnt;
        logic [31:0] hiBefore, loBefore;
        @(negedge clk);
        hiBefore = mHi;
        loBefore = mLo;
        bus.start    = 1'b1;
        bus.mdu_type = t;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.req      = r;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.mdu_type = 4'd0;
        bus.src_a    = 32'd0;
        bus.src_b    = 32'd0;
        bus.req      = 1'b0;
        if (expN > 0) begin
            check({name, " hi held during busy"}, bus.hi, hiBefore);
            check({name, " lo held during busy"}, bus.lo, loBefore);
        end
        busyCnt = 0;
        while (bus.busy && busyCnt < 40) begin
            busyCnt++;
            @(posedge clk);
            #1;
        end
        check({name, " busy cycles"}, 32'(busyCnt), 32'(expN));
        check({name, " hi"}, bus.hi, expHi);
        check({name, " lo"}, bus.lo, expLo);
        bus.mdu_type = 4'd5;
        #1 check({name, " mfhi"}, bus.mdu_out, expHi);
        bus.mdu_type = 4'd6;
        #1 check({name, " mflo"}, bus.mdu_out, expLo);
        bus.mdu_type = 4'd0;
        #1 check({name, " idle read"}, bus.mdu_out, 32'd0);
        mHi = expHi;
        mLo = expLo;
    endtask

    // Hazard-unit contract: no start may arrive while busy.
    always @(posedge clk) begin
        if (reset && bus.start && bus.busy) begin
            nFails++;
            $display("FAIL protocol: start=1 while busy=1, required start=0");
        end
    end

    initial begin
        logic [3:0]  t;
        logic [31:0] a, b, eHi, eLo;
        bit          r;
        int          n;

        vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5,  "mult"};
        vecs[1]  = '{4'd2, 32'hFFFFFFFE, 32'd3,        1'b0, 32'h00000002, 32'hFFFFFFFA, 5,  "multu"};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div"};
        vecs[3]  = '{4'd4, 32'd7,        32'd2,        1'b0, 32'd1,        32'd3,        10, "divu"};
        vecs[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 10, "div overflow"};
        vecs[5]  = '{4'd4, 32'd5,        32'd0,        1'b0, 32'd0,        32'h80000000, 10, "divu by zero"};
        vecs[6]  = '{4'd8, 32'h12345678, 32'd0,        1'b0, 32'd0,        32'h12345678, 0,  "mtlo"};
        vecs[7]  = '{4'd7, 32'hDEADBEEF, 32'd0,        1'b1, 32'd0,        32'h12345678, 0,  "mthi killed"};
        vecs[8]  = '{4'd1, 32'd3,        32'd3,        1'b1, 32'd0,        32'h12345678, 0,  "mult killed"};
        vecs[9]  = '{4'd7, 32'hCAFEF00D, 32'd0,        1'b0, 32'hCAFEF00D, 32'h12345678, 0,  "mthi"};
        vecs[10] = '{4'd0, 32'h11111111, 32'd1,        1'b0, 32'hCAFEF00D, 32'h12345678, 0,  "type none"};
        vecs[11] = '{4'd12, 32'h22222222, 32'd1,       1'b0, 32'hCAFEF00D, 32'h12345678, 0,  "type undefined"};

        bus.start    = 1'b0;
        bus.mdu_type = 4'd0;
        bus.src_a    = 32'd0;
        bus.src_b    = 32'd0;
        bus.req      = 1'b0;
        mHi = 32'd0;
        mLo = 32'd0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset mdu_out", bus.mdu_out, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++)
            runOp(vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].r,
                  vecs[i].expHi, vecs[i].expLo, vecs[i].expN, vecs[i].name);

        // Reset during the fourth busy cycle of a divide discards everything.
        @(negedge clk);
        bus.start = 1'b1; bus.mdu_type = 4'd3; bus.src_a = 32'd100; bus.src_b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.mdu_type = 4'd0;
        repeat (3) begin @(posedge clk); #1; end
        check("midop busy before reset", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("midop reset busy", 32'(bus.busy), 32'd0);
        check("midop reset hi", bus.hi, 32'd0);
        check("midop reset lo", bus.lo, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("midop no late commit lo", bus.lo, 32'd0);
        mHi = 32'd0;
        mLo = 32'd0;
        runOp(4'd1, 32'd6, 32'd7, 1'b0, 32'd0, 32'd42, 5, "mult after reset");

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            t = 4'($urandom_range(0, 10));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = 32'($signed(-$urandom_range(0, 1000))); b = 32'($urandom_range(1, 9)); end
                default: ;
            endcase
            r = ($urandom_range(0, 7) == 0);
            model(t, a, b, r, mHi, mLo, eHi, eLo, n);
            runOp(t, a, b, r, eHi, eLo, n, $sformatf("rand%0d t%0d", i, t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
